// File: rtl/serial_frame_scheduler.sv
// serial_frame_scheduler: round-robin sharing of one serial Mealy FSM among NREQ requesters
// Ports: clk/rst (sync, active-high); req/req_data from requesters, ack one-hot grant pulse;
// fsm_rst_n/fsm_din drive the shared FSM, fsm_dout is its Mealy output;
// busy while a frame is in flight; done pulse with done_id and hit_cnt of the finished frame.
module serial_frame_scheduler #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic                  fsm_rst_n,
  output logic                  fsm_din,
  input  logic                  fsm_dout,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [CW-1:0]         hit_cnt
);
  localparam int BW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;
  state_t state, nxt;
  logic [IDW-1:0] ptr, id, gid;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0] bcnt;
  logic [CW-1:0] wcnt;
  logic live, last;
  int off, best;
  assign last = bcnt == BW'(WIDTH - 1);
  // the set requester with the smallest upward distance from the pointer wins
  always_comb begin
    gid = '0;
    best = NREQ;
    off = 0;
    for (int i = 0; i < NREQ; i++) begin
      off = (i >= int'(ptr)) ? i - int'(ptr) : i + NREQ - int'(ptr);
      if (req[i] && off < best) begin
        best = off;
        gid = IDW'(i);
      end
    end
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = |req ? CLEAR : IDLE;
      CLEAR:   nxt = SHIFT;
      SHIFT:   nxt = last ? REPORT : SHIFT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      id <= '0;
      sreg <= '0;
      bcnt <= '0;
      wcnt <= '0;
      ack <= '0;
      done_id <= '0;
      hit_cnt <= '0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      ack <= '0;
      if (state == IDLE && |req) begin
        id <= gid;
        sreg <= req_data[gid*WIDTH +: WIDTH];
        bcnt <= '0;
        wcnt <= '0;
        ack <= NREQ'(1) << gid;
      end
      if (state == SHIFT) begin
        sreg <= sreg << 1;
        bcnt <= bcnt + BW'(1);
        wcnt <= wcnt + CW'(fsm_dout);
        if (last) begin
          hit_cnt <= wcnt + CW'(fsm_dout);
          done_id <= id;
        end
      end
      if (state == REPORT) ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
    end
  end
  assign busy = state != IDLE;
  assign done = state == REPORT;
  assign fsm_din = state == SHIFT && sreg[WIDTH-1];
  // live keeps the FSM in reset through the first cycle after rst is released
  assign fsm_rst_n = live && !rst && state != CLEAR;
endmodule

// File: tb/tb_serial_frame_scheduler.sv
// tb_serial_frame_scheduler: scoreboard bench for serial_frame_scheduler with a behavioural FSM model
module tb_serial_frame_scheduler;
  localparam int NREQ = 4, IDW = 2, WIDTH = 8, CW = 4;
  typedef struct {int id; int cnt;} exp_t;
  logic clk = 0, rst = 1;
  logic [NREQ-1:0] req = '0;
  logic [WIDTH-1:0] dat [NREQ];
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0] ack;
  logic fsm_rst_n, fsm_din, fsm_dout, busy, done;
  logic [IDW-1:0] done_id;
  logic [CW-1:0] hit_cnt;
  logic s = 0;
  int mode = 0, exp_ptr = 0, n_cmp = 0, n_bad = 0, cyc = 0;
  exp_t q [$];
  int dq [$];
  exp_t e;

  serial_frame_scheduler #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .fsm_rst_n(fsm_rst_n), .fsm_din(fsm_din), .fsm_dout(fsm_dout),
    .busy(busy), .done(done), .done_id(done_id), .hit_cnt(hit_cnt));

  always #5 clk = ~clk;
  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = dat[i];
  end
  // mode 0: dout follows din; mode 1: "11" detector, dout=1 when din=1 while the last bit was 1
  assign fsm_dout = mode != 0 ? (fsm_din & s) : fsm_din;
  always @(posedge clk) s <= fsm_rst_n ? fsm_din : 1'b0;

  function automatic int ref_cnt(logic [WIDTH-1:0] d, int m);
    logic [WIDTH-1:0] p;
    p = d & (d << 1);
    return m != 0 ? $countones(p) : $countones(d);
  endfunction

  function automatic int pick(logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++)
      if (m[(exp_ptr + k) % NREQ]) return (exp_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1;
    req = '0;
    repeat (n) step();
    rst = 0;
    exp_ptr = 0;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = |ack;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: got no ack expected one within 64 cycles");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got %0d frames outstanding expected 0", q.size());
      q.delete();
    end
    step();
  endtask

  task automatic run_set(logic [NREQ-1:0] m);
    bit ok;
    int id;
    req = m;
    while (m != 0) begin
      id = pick(m);
      q.push_back('{id: id, cnt: ref_cnt(dat[id], mode)});
      exp_ptr = (id + 1) % NREQ;
      wait_ack(ok);
      if (!ok) begin
        req = '0;
        q.delete();
        return;
      end
      chk("ack_grant", int'(ack), 1 << id);
      req[id] = 1'b0;
      m[id] = 1'b0;
      dat[id] = WIDTH'($urandom);
    end
    drain();
  endtask

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      dq.push_back(cyc);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_unexpected: got done with id %0d expected no done", done_id);
      end else begin
        e = q.pop_front();
        chk("done_id", int'(done_id), e.id);
        chk("hit_cnt", int'(hit_cnt), e.cnt);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a5;
    bit ok;
    logic [NREQ-1:0] m;
    foreach (dat[i]) dat[i] = '0;
    rst = 1;
    req = '1;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("rst_ack", int'(ack), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_fsm_rst_n", int'(fsm_rst_n), 0);
      chk("rst_fsm_din", int'(fsm_din), 0);
    end
    step();
    rst = 0;
    req = '0;
    @(negedge clk);
    chk("release_fsm_rst_n", int'(fsm_rst_n), 0);
    chk("release_busy", int'(busy), 0);
    step();
    @(negedge clk);
    chk("idle_fsm_rst_n", int'(fsm_rst_n), 1);
    // single frame with exact cycle timing
    a5 = 8'hA5;
    dat[0] = a5;
    req = 4'b0001;
    q.push_back('{id: 0, cnt: ref_cnt(a5, 0)});
    exp_ptr = 1;
    @(negedge clk);
    chk("single_ack", int'(ack), 1);
    chk("single_clear_rst_n", int'(fsm_rst_n), 0);
    chk("single_busy", int'(busy), 1);
    req = '0;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      chk("single_din", int'(fsm_din), int'(a5[WIDTH-1-i]));
      chk("single_no_done", int'(done), 0);
    end
    @(negedge clk);
    chk("single_done", int'(done), 1);
    drain();
    // all four held from reset: RR order and back-to-back frame period
    do_reset(2);
    foreach (dat[i]) dat[i] = WIDTH'($urandom);
    dq.delete();
    run_set(4'b1111);
    chk("all4_done_count", dq.size(), 4);
    for (int i = 0; i + 1 < dq.size(); i++) chk("all4_period", dq[i+1] - dq[i], WIDTH + 3);
    // RR fairness after serving id 2
    dat[2] = WIDTH'($urandom);
    run_set(4'b0100);
    dat[1] = WIDTH'($urandom);
    dat[3] = WIDTH'($urandom);
    run_set(4'b1010);
    // count boundaries
    mode = 0;
    dat[0] = 8'hFF;
    run_set(4'b0001);
    dat[0] = 8'h00;
    run_set(4'b0001);
    mode = 1;
    dat[0] = 8'hFF;
    run_set(4'b0001);
    dat[0] = 8'hE7;
    run_set(4'b0001);
    // abort mid-SHIFT with req[2] held
    mode = 0;
    dat[2] = WIDTH'($urandom);
    req = 4'b0100;
    wait_ack(ok);
    chk("abort_pre_ack", int'(ack), 4);
    repeat (4) @(posedge clk);
    #1;
    rst = 1;
    step();
    rst = 0;
    exp_ptr = 0;
    q.push_back('{id: pick(4'b0100), cnt: ref_cnt(dat[2], mode)});
    exp_ptr = 3;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done_id", int'(done_id), 0);
    chk("abort_hit_cnt", int'(hit_cnt), 0);
    @(negedge clk);
    chk("abort_regrant", int'(ack), 4);
    req = '0;
    drain();
    // randomized rounds
    for (int r = 0; r < 25; r++) begin
      mode = int'($urandom_range(0, 1));
      foreach (dat[i]) begin
        case ($urandom_range(0, 7))
          0: dat[i] = 8'h00;
          1: dat[i] = 8'hFF;
          default: dat[i] = WIDTH'($urandom);
        endcase
      end
      m = NREQ'($urandom_range(1, 15));
      run_set(m);
      if ($urandom_range(0, 5) == 0) do_reset(1 + int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 3)) step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
